afu_write_ctrl: RTL

AFU_WRITE_CTRL -- requirements
Module: afu_write_ctrl

---
 rtl/afu_pkg.sv | 16 +
 rtl/afu_credit_counter.sv | 41 ++++
 rtl/afu_write_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/afu_pkg.sv
// Shared definitions for the AFU write path: line width, default address width
// and the write-controller state encoding.
package afu_pkg;

  localparam int unsigned CL_WIDTH        = 512;
  localparam int unsigned ADDR_WIDTH_DFLT = 32;
  localparam int unsigned CNT_WIDTH       = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/afu_credit_counter.sv
// Outstanding-write tracker: counts writes issued but not yet acknowledged and
// flags when the host-side limit is reached.
module afu_credit_counter
  import afu_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 16,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full_c
);

  logic [CW-1:0] count_q, count_d;

  // Simultaneous issue and response cancel; never underflow on a stray response.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full_c = (count_q == CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/afu_write_ctrl.sv
// Write controller: drains the transpose-engine output FIFO into host write
// requests at consecutive cache-line addresses, bounded by outstanding credit.
module afu_write_ctrl
  import afu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DFLT,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctx_start,
  input  logic [CNT_WIDTH-1:0]  ctx_length,
  input  logic [ADDR_WIDTH-1:0] ctx_dst_addr,
  input  logic [CL_WIDTH-1:0]   output_fifo_dout,
  output logic                  output_fifo_re,
  input  logic                  output_fifo_empty,
  output logic                  wr_req_valid,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [CL_WIDTH-1:0]   wr_req_data,
  input  logic                  wr_req_almost_full,
  input  logic                  wr_rsp_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  rsp_overflow
);

  wr_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  length_q, length_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [CNT_WIDTH-1:0]  acked_q, acked_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic active_c;
  logic re_c;
  logic rsp_ok_c;
  logic ctx_clr_c;
  logic cred_full_c;

  afu_credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk    (clk),
    .reset  (reset),
    .clr    (ctx_clr_c),
    .inc    (re_c),
    .dec    (rsp_ok_c),
    .full_c (cred_full_c)
  );

  always_comb begin
    state_d     = state_q;
    length_d    = length_q;
    issued_d    = issued_q;
    acked_d     = acked_q;
    next_addr_d = next_addr_q;
    wr_addr_d   = wr_addr_q;
    ovf_d       = ovf_q;
    ctx_clr_c   = 1'b0;

    active_c = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    re_c     = (state_q == ST_RUN) && !output_fifo_empty && !wr_req_almost_full &&
               (issued_q < length_q) && !cred_full_c && !reset;
    rsp_ok_c = wr_rsp_valid && active_c && (acked_q != length_q);

    // The FIFO presents data one cycle after the read, so the request follows it.
    wr_valid_d = re_c;
    if (re_c) begin
      issued_d    = issued_q + CNT_WIDTH'(1);
      next_addr_d = next_addr_q + ADDR_WIDTH'(1);
      wr_addr_d   = next_addr_q;
    end
    if (rsp_ok_c) begin
      acked_d = acked_q + CNT_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ctx_start) begin
          ctx_clr_c   = 1'b1;
          length_d    = ctx_length;
          next_addr_d = ctx_dst_addr;
          issued_d    = '0;
          acked_d     = '0;
          ovf_d       = 1'b0;
          state_d     = (ctx_length != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (re_c && (issued_d == length_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (acked_d == length_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stray acknowledgement still wins over a same-cycle start clear.
    if (wr_rsp_valid && !rsp_ok_c) begin
      ovf_d = 1'b1;
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      length_q    <= '0;
      issued_q    <= '0;
      acked_q     <= '0;
      next_addr_q <= '0;
      wr_addr_q   <= '0;
      wr_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      issued_q    <= issued_d;
      acked_q     <= acked_d;
      next_addr_q <= next_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_valid_q  <= wr_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  // A request pending across a reset assertion is dropped, not presented.
  assign output_fifo_re = re_c;
  assign wr_req_valid   = wr_valid_q && !reset;
  assign wr_req_addr    = wr_addr_q;
  assign wr_req_data    = wr_req_valid ? output_fifo_dout : '0;
  assign busy           = busy_q;
  assign done           = done_q;
  assign rsp_overflow   = ovf_q;

endmodule
